// File: rtl/cpu_control_sequencer_if.sv
// Memory port bundle between the control sequencer and memory.
// Requests are held until mem_ready completes them.
interface cpu_control_sequencer_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the CPU datapath.
// Fetches opcode/operand bytes and holds the C/Z/N status flags.
module cpu_control_sequencer #(
    parameter logic [3:0] OP_ADD = 4'h0,
    parameter logic [3:0] OP_AND = 4'h1,
    parameter logic [3:0] OP_OR  = 4'h2,
    parameter logic [3:0] OP_EOR = 4'h3
) (
    input  logic        clk,
    input  logic        rst_n,
    cpu_control_sequencer_if.master mem,
    input  logic [7:0]  reg_a,
    input  logic [7:0]  reg_x,
    input  logic [7:0]  reg_y,
    input  logic [15:0] reg_pc,
    input  logic        alu_carry_out,
    input  logic        alu_negative,
    input  logic        alu_zero,
    output logic [3:0]  alu_op,
    output logic        alu_carry_in,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [2:0]  reg_src_sel,
    output logic        reg_a_write,
    output logic        reg_x_write,
    output logic        reg_y_write,
    output logic        reg_pc_write,
    output logic        pc_increment,
    output logic        sp_push,
    output logic        sp_pop,
    output logic        reg_sp_write,
    output logic [7:0]  operand_data,
    output logic [15:0] pc_branch_target,
    output logic        flag_c,
    output logic        flag_z,
    output logic        flag_n,
    output logic        halted,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        OPERAND  = 3'd2,
        ADDR_HI  = 3'd3,
        MEM_READ = 3'd4,
        STORE    = 3'd5,
        EXECUTE  = 3'd6,
        HALT     = 3'd7
    } state_t;

    // a_sel: A/X/Y/zero; b_sel: mem/A/X/Y
    localparam logic [1:0] SA_A = 2'b00;
    localparam logic [1:0] SA_X = 2'b01;
    localparam logic [1:0] SA_Y = 2'b10;
    localparam logic [1:0] SA_Z = 2'b11;
    localparam logic [1:0] SB_M = 2'b00;
    localparam logic [1:0] SB_A = 2'b01;
    localparam logic [1:0] SB_X = 2'b10;
    localparam logic [1:0] SB_Y = 2'b11;

    state_t     state_q, state_d;
    logic [7:0] ir;
    logic [7:0] operand_lo, operand_hi;
    logic       is_implied, is_operand, any_wr;
    logic       unused_regs;

    assign unused_regs      = ^{reg_x, reg_y};
    assign sp_push          = 1'b0;
    assign sp_pop           = 1'b0;
    assign reg_sp_write     = 1'b0;
    assign mem.mem_wdata    = reg_a;
    assign pc_branch_target = {operand_hi, operand_lo};
    assign halted           = (state_q == HALT);
    assign state_dbg        = state_q;
    assign any_wr = reg_a_write | reg_x_write | reg_y_write;

    always_comb begin
        is_implied = 1'b0;
        is_operand = 1'b0;
        case (ir)
            8'hAA, 8'hA8, 8'h8A, 8'h98, 8'hE8,
            8'hC8, 8'h18, 8'h38, 8'hEA:
                is_implied = 1'b1;
            8'hA9, 8'hA2, 8'hA0, 8'hA5, 8'h69,
            8'h29, 8'h09, 8'h49, 8'h4C, 8'h85:
                is_operand = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        mem.mem_addr = reg_pc;
        mem.mem_rd   = 1'b0;
        mem.mem_wr   = 1'b0;
        alu_op       = OP_OR;
        alu_carry_in = 1'b0;
        alu_a_sel    = SA_Z;
        alu_b_sel    = SB_M;
        reg_src_sel  = 3'b000;
        reg_a_write  = 1'b0;
        reg_x_write  = 1'b0;
        reg_y_write  = 1'b0;
        reg_pc_write = 1'b0;
        pc_increment = 1'b0;
        // Requests are gated so reset drops them at once
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem.mem_rd = 1'b1;
                    if (mem.mem_ready) begin
                        pc_increment = 1'b1;
                        state_d      = DECODE;
                    end
                end
                DECODE: begin
                    unique case (1'b1)
                        is_implied: state_d = EXECUTE;
                        is_operand: state_d = OPERAND;
                        default:    state_d = HALT;
                    endcase
                end
                OPERAND: begin
                    mem.mem_rd = 1'b1;
                    if (mem.mem_ready) begin
                        pc_increment = 1'b1;
                        case (ir)
                            8'hA5:   state_d = MEM_READ;
                            8'h85:   state_d = STORE;
                            8'h4C:   state_d = ADDR_HI;
                            default: state_d = EXECUTE;
                        endcase
                    end
                end
                ADDR_HI: begin
                    mem.mem_rd = 1'b1;
                    if (mem.mem_ready) state_d = EXECUTE;
                end
                MEM_READ: begin
                    mem.mem_addr = {8'h00, operand_lo};
                    mem.mem_rd   = 1'b1;
                    if (mem.mem_ready) state_d = EXECUTE;
                end
                STORE: begin
                    mem.mem_addr = {8'h00, operand_lo};
                    mem.mem_wr   = 1'b1;
                    if (mem.mem_ready) state_d = FETCH;
                end
                EXECUTE: begin
                    state_d = FETCH;
                    case (ir)
                        8'hA9, 8'hA5: reg_a_write = 1'b1;
                        8'hA2: reg_x_write = 1'b1;
                        8'hA0: reg_y_write = 1'b1;
                        8'h69: begin
                            alu_op       = OP_ADD;
                            alu_a_sel    = SA_A;
                            alu_carry_in = flag_c;
                            reg_a_write  = 1'b1;
                        end
                        8'h29: begin
                            alu_op      = OP_AND;
                            alu_a_sel   = SA_A;
                            reg_a_write = 1'b1;
                        end
                        8'h09: begin
                            alu_a_sel   = SA_A;
                            reg_a_write = 1'b1;
                        end
                        8'h49: begin
                            alu_op      = OP_EOR;
                            alu_a_sel   = SA_A;
                            reg_a_write = 1'b1;
                        end
                        8'hAA: begin
                            alu_b_sel   = SB_A;
                            reg_x_write = 1'b1;
                        end
                        8'hA8: begin
                            alu_b_sel   = SB_A;
                            reg_y_write = 1'b1;
                        end
                        8'h8A: begin
                            alu_b_sel   = SB_X;
                            reg_a_write = 1'b1;
                        end
                        8'h98: begin
                            alu_b_sel   = SB_Y;
                            reg_a_write = 1'b1;
                        end
                        8'hE8: begin
                            alu_op      = OP_ADD;
                            alu_a_sel   = SA_X;
                            reg_x_write = 1'b1;
                        end
                        8'hC8: begin
                            alu_op      = OP_ADD;
                            alu_a_sel   = SA_Y;
                            reg_y_write = 1'b1;
                        end
                        8'h4C: reg_pc_write = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir           <= 8'hEA;
            operand_lo   <= 8'h00;
            operand_hi   <= 8'h00;
            operand_data <= 8'h00;
            flag_c       <= 1'b0;
            flag_z       <= 1'b0;
            flag_n       <= 1'b0;
        end else begin
            case (state_q)
                FETCH:
                    if (mem.mem_ready) ir <= mem.mem_rdata;
                DECODE:
                    // INX/INY add the constant one through the mem port
                    if (ir == 8'hE8 || ir == 8'hC8)
                        operand_data <= 8'h01;
                OPERAND:
                    if (mem.mem_ready) begin
                        operand_lo   <= mem.mem_rdata;
                        operand_data <= mem.mem_rdata;
                    end
                ADDR_HI:
                    if (mem.mem_ready) operand_hi <= mem.mem_rdata;
                MEM_READ:
                    if (mem.mem_ready) operand_data <= mem.mem_rdata;
                EXECUTE: begin
                    if (any_wr) begin
                        flag_z <= alu_zero;
                        flag_n <= alu_negative;
                    end
                    case (ir)
                        8'h69:   flag_c <= alu_carry_out;
                        8'h18:   flag_c <= 1'b0;
                        8'h38:   flag_c <= 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench: datapath and memory models around the sequencer.
// Programs run from address 0; results checked against hand values.
module tb_cpu_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  reg_a, reg_x, reg_y;
    logic [15:0] reg_pc;
    logic        alu_carry_out, alu_negative, alu_zero;
    logic [3:0]  alu_op;
    logic        alu_carry_in;
    logic [1:0]  alu_a_sel, alu_b_sel;
    logic [2:0]  reg_src_sel;
    logic        reg_a_write, reg_x_write, reg_y_write;
    logic        reg_pc_write, pc_increment;
    logic        sp_push, sp_pop, reg_sp_write;
    logic [7:0]  operand_data;
    logic [15:0] pc_branch_target;
    logic        flag_c, flag_z, flag_n, halted;
    logic [2:0]  state_dbg;

    cpu_control_sequencer_if mif();

    cpu_control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .mem(mif),
        .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y),
        .reg_pc(reg_pc),
        .alu_carry_out(alu_carry_out),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_op(alu_op), .alu_carry_in(alu_carry_in),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .reg_src_sel(reg_src_sel),
        .reg_a_write(reg_a_write), .reg_x_write(reg_x_write),
        .reg_y_write(reg_y_write), .reg_pc_write(reg_pc_write),
        .pc_increment(pc_increment),
        .sp_push(sp_push), .sp_pop(sp_pop),
        .reg_sp_write(reg_sp_write),
        .operand_data(operand_data),
        .pc_branch_target(pc_branch_target),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
        .halted(halted), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // datapath model
    logic [7:0] opa, opb, alu_res;
    logic [8:0] sum;
    always_comb begin
        case (alu_a_sel)
            2'd0: opa = reg_a;
            2'd1: opa = reg_x;
            2'd2: opa = reg_y;
            default: opa = 8'h00;
        endcase
        case (alu_b_sel)
            2'd0: opb = operand_data;
            2'd1: opb = reg_a;
            2'd2: opb = reg_x;
            default: opb = reg_y;
        endcase
        sum = {1'b0, opa} + {1'b0, opb} + {8'h00, alu_carry_in};
        case (alu_op)
            4'd0: alu_res = sum[7:0];
            4'd1: alu_res = opa & opb;
            4'd2: alu_res = opa | opb;
            default: alu_res = opa ^ opb;
        endcase
        alu_carry_out = (alu_op == 4'd0) ? sum[8] : 1'b0;
        alu_zero      = (alu_res == 8'h00);
        alu_negative  = alu_res[7];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a <= 8'h00; reg_x <= 8'h00;
            reg_y <= 8'h00; reg_pc <= 16'h0000;
        end else begin
            if (reg_a_write) reg_a <= alu_res;
            if (reg_x_write) reg_x <= alu_res;
            if (reg_y_write) reg_y <= alu_res;
            if (reg_pc_write) reg_pc <= pc_branch_target;
            else if (pc_increment) reg_pc <= reg_pc + 16'd1;
        end
    end

    // memory model with programmable wait states
    logic [7:0]  mem_arr [0:65535];
    int          dly = 0;
    int          wcnt = 0;
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = 16'h0;
    logic [7:0]  ld_data = 8'h0;
    logic        req;

    assign req = mif.mem_rd | mif.mem_wr;
    assign mif.mem_rdata = mem_arr[mif.mem_addr];
    assign mif.mem_ready = req && (wcnt >= dly);

    always @(posedge clk) begin
        if (ld_en) mem_arr[ld_addr] <= ld_data;
        if (!rst_n) wcnt <= 0;
        else if (mif.mem_ready) begin
            wcnt <= 0;
            if (mif.mem_wr) mem_arr[mif.mem_addr] <= mif.mem_wdata;
        end else if (req) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    // protocol monitors
    int          stab_bad = 0, strobe_bad = 0, both_bad = 0;
    int          pcw_cnt = 0;
    logic        prev_wait = 1'b0;
    logic [15:0] p_addr;
    logic        p_rd, p_wr;
    always @(negedge clk) begin
        if (reg_pc_write) pcw_cnt++;
        if (reg_pc_write && pc_increment) both_bad++;
        if (req && !mif.mem_ready &&
            (reg_a_write | reg_x_write | reg_y_write |
             reg_pc_write | pc_increment))
            strobe_bad++;
        if (prev_wait && req &&
            (mif.mem_addr != p_addr || mif.mem_rd != p_rd ||
             mif.mem_wr != p_wr))
            stab_bad++;
        prev_wait = req && !mif.mem_ready;
        p_addr = mif.mem_addr;
        p_rd = mif.mem_rd;
        p_wr = mif.mem_wr;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic start();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_to_pc(input string tag, input logic [15:0] pc,
                             input int budget);
        logic hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (state_dbg == 3'd0 && reg_pc == pc) hit = 1'b1;
        end
        chk(tag, {31'b0, hit}, 32'd1);
    endtask

    int pcw0, rd_seen;
    logic hit_h;

    initial begin
        // LDA #42, zero wait
        rst_n = 1'b0; dly = 0;
        poke(16'h0000, 8'hA9); poke(16'h0001, 8'h42);
        #1;
        chk("rst_state", {29'b0, state_dbg}, 32'd0);
        chk("rst_rd", {31'b0, mif.mem_rd}, 32'd0);
        chk("rst_flags", {29'b0, flag_c, flag_z, flag_n}, 32'd0);
        chk("rst_opd", {24'b0, operand_data}, 32'd0);
        start();
        @(negedge clk);
        chk("c1_state", {29'b0, state_dbg}, 32'd0);
        chk("c1_rd", {31'b0, mif.mem_rd}, 32'd1);
        @(negedge clk);
        chk("c2_state", {29'b0, state_dbg}, 32'd1);
        @(negedge clk);
        chk("c3_state", {29'b0, state_dbg}, 32'd2);
        @(negedge clk);
        chk("c4_state", {29'b0, state_dbg}, 32'd6);
        chk("c4_awr", {31'b0, reg_a_write}, 32'd1);
        chk("c4_res", {24'b0, alu_res}, 32'h42);
        run_to_pc("lda_pc", 16'h0002, 10);
        chk("lda_a", {24'b0, reg_a}, 32'h42);
        chk("lda_zn", {30'b0, flag_z, flag_n}, 32'd0);

        // ADC with carry out then carry in
        rst_n = 1'b0;
        poke(16'h0000, 8'hA9); poke(16'h0001, 8'hFF);
        poke(16'h0002, 8'h69); poke(16'h0003, 8'h01);
        poke(16'h0004, 8'h38); poke(16'h0005, 8'h69);
        poke(16'h0006, 8'h00);
        start();
        run_to_pc("adc1_pc", 16'h0004, 40);
        chk("adc1_a", {24'b0, reg_a}, 32'h00);
        chk("adc1_czn", {29'b0, flag_c, flag_z, flag_n}, 32'b110);
        run_to_pc("adc2_pc", 16'h0007, 40);
        chk("adc2_a", {24'b0, reg_a}, 32'h01);
        chk("adc2_czn", {29'b0, flag_c, flag_z, flag_n}, 32'b000);

        // JMP abs
        rst_n = 1'b0;
        poke(16'h0000, 8'h4C); poke(16'h0001, 8'h34);
        poke(16'h0002, 8'h12);
        start();
        pcw0 = pcw_cnt;
        run_to_pc("jmp_pc", 16'h1234, 40);
        chk("jmp_pulses", pcw_cnt - pcw0, 32'd1);
        chk("jmp_tgt", {16'b0, pc_branch_target}, 32'h1234);
        chk("jmp_addr", {16'b0, mif.mem_addr}, 32'h1234);

        // store/load through zero page with wait states
        rst_n = 1'b0; dly = 3;
        poke(16'h0000, 8'hA9); poke(16'h0001, 8'h5A);
        poke(16'h0002, 8'h85); poke(16'h0003, 8'h10);
        poke(16'h0004, 8'hA9); poke(16'h0005, 8'h00);
        poke(16'h0006, 8'hA5); poke(16'h0007, 8'h10);
        poke(16'h0010, 8'h00);
        start();
        run_to_pc("zp_sta_pc", 16'h0004, 100);
        chk("zp_mem", {24'b0, mem_arr[16'h0010]}, 32'h5A);
        run_to_pc("zp_pc", 16'h0008, 100);
        chk("zp_a", {24'b0, reg_a}, 32'h5A);
        chk("zp_zn", {30'b0, flag_z, flag_n}, 32'd0);

        // LDX #FF, INX, TXA
        rst_n = 1'b0; dly = 0;
        poke(16'h0000, 8'hA2); poke(16'h0001, 8'hFF);
        poke(16'h0002, 8'hE8); poke(16'h0003, 8'h8A);
        start();
        run_to_pc("inx_pc", 16'h0003, 40);
        chk("inx_x", {24'b0, reg_x}, 32'h00);
        chk("inx_czn", {29'b0, flag_c, flag_z, flag_n}, 32'b010);
        run_to_pc("txa_pc", 16'h0004, 40);
        chk("txa_a", {24'b0, reg_a}, 32'h00);
        chk("txa_czn", {29'b0, flag_c, flag_z, flag_n}, 32'b010);

        // unsupported opcode halts
        rst_n = 1'b0;
        poke(16'h0000, 8'h02);
        start();
        hit_h = 1'b0;
        for (int i = 0; i < 10 && !hit_h; i++) begin
            @(negedge clk);
            hit_h = halted;
        end
        chk("halt", {31'b0, hit_h}, 32'd1);
        chk("halt_state", {29'b0, state_dbg}, 32'd7);
        rd_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mif.mem_rd) rd_seen++;
        end
        chk("halt_no_rd", rd_seen, 32'd0);

        // reset in the middle of a fetch wait
        rst_n = 1'b0; dly = 2;
        poke(16'h0000, 8'h38); poke(16'h0001, 8'hA9);
        poke(16'h0002, 8'h80);
        start();
        run_to_pc("mid_pc", 16'h0003, 60);
        chk("mid_cn", {30'b0, flag_c, flag_n}, 32'b11);
        chk("mid_rd", {31'b0, mif.mem_rd}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rd_drop", {31'b0, mif.mem_rd}, 32'd0);
        chk("mid_flags", {29'b0, flag_c, flag_z, flag_n}, 32'd0);
        chk("mid_state", {29'b0, state_dbg}, 32'd0);

        chk("stable_wait", stab_bad, 32'd0);
        chk("strobe_wait", strobe_bad, 32'd0);
        chk("pcw_pcinc", both_bad, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
